// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI burst responder over a word-addressed RAM array.
module axi_mem_responder #(
  parameter int    DEPTH_LOG2 = 12,
  parameter string INIT_FILE  = "",
  parameter int    READ_LAT   = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rlast,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic        proto_err
);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
`ifdef AXI_MEM_WAIT_EN
  localparam int WAIT = READ_LAT;
`else
  localparam int WAIT = 0 * READ_LAT;
`endif
  localparam logic [7:0] WAIT_END = 8'(WAIT == 0 ? 0 : WAIT - 1);
  logic [31:0] mem [2**DEPTH_LOG2];
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx;
  logic [7:0] r_len, r_cnt, r_wait, w_len, w_cnt;
  logic ar_fire, r_fire, aw_fire, w_fire, w_stall, unused;
  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign unused  = ^{arsize, awsize, araddr[31:DEPTH_LOG2+2], araddr[1:0],
                     awaddr[31:DEPTH_LOG2+2], awaddr[1:0]};
`ifdef AXI_MEM_WAIT_EN
  logic w_first;
  always_ff @(posedge clk) w_first <= aw_fire;
  assign w_stall = w_first;
`else
  assign w_stall = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= R_IDLE;
      w_state   <= W_IDLE;
      proto_err <= 1'b0;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
      if (w_fire && (wlast != (w_cnt == w_len))) proto_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      r_idx  <= araddr[DEPTH_LOG2+1:2];
      r_len  <= arlen;
      r_cnt  <= '0;
      r_wait <= '0;
    end else begin
      if (r_fire) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= r_cnt + 8'd1;
      end
      if (r_state == R_WAIT) r_wait <= r_wait + 8'd1;
    end
    if (aw_fire) begin
      w_idx <= awaddr[DEPTH_LOG2+1:2];
      w_len <= awlen;
      w_cnt <= '0;
    end else if (w_fire) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 8'd1;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (w_fire && wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
  always_comb begin
    r_next = (r_state == R_IDLE && ar_fire) ? (WAIT == 0 ? R_BURST : R_WAIT) :
             (r_state == R_WAIT && r_wait == WAIT_END) ? R_BURST :
             (r_state == R_BURST && r_fire && rlast) ? R_IDLE : r_state;
    w_next = (w_state == W_IDLE && aw_fire) ? W_DATA :
             (w_state == W_DATA && w_fire && w_cnt == w_len) ? W_RESP :
             (w_state == W_RESP && bready) ? W_IDLE : w_state;
  end
  always_comb begin
    arready = rstn && r_state == R_IDLE;
    rvalid  = r_state == R_BURST;
    rlast   = rvalid && r_cnt == r_len;
    rdata   = rvalid ? mem[r_idx] : '0;
    awready = rstn && w_state == W_IDLE;
    wready  = rstn && w_state == W_DATA && !w_stall;
    bvalid  = w_state == W_RESP;
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed bench for axi_mem_responder in its default (no wait) build.
module tb_axi_mem_responder;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  arlen = '0, awlen = '0;
  logic [2:0]  arsize = 3'd2, awsize = 3'd2;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, rlast, awready, wready, bvalid, proto_err;
  logic [31:0] rdata;
  int          compared = 0, mismatched = 0;
  logic [31:0] wd [4];
  logic [31:0] rd [4];
  logic        rl [4];
  int          beats, cycles;

  axi_mem_responder dut (
    .clk(clk), .rstn(rstn),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] strb, input int last_beat);
    int t;
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
    #1; t = 0;
    while (!awready && t < 20) begin @(negedge clk); #1; t++; end
    chk("aw_wait", 32'(t < 20), 32'd1);
    @(posedge clk);
    for (int b = 0; b <= len; b++) begin
      @(negedge clk);
      awvalid = 1'b0;
      wvalid = 1'b1; wdata = wd[b]; wstrb = strb; wlast = (b == last_beat);
      #1; t = 0;
      while (!wready && t < 20) begin @(negedge clk); #1; t++; end
      chk("w_wait", 32'(t < 20), 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    #1; t = 0;
    while (!bvalid && t < 20) begin @(negedge clk); #1; t++; end
    chk("b_wait", 32'(t < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bready = 1'b0;
    #1 chk("awready_after_b", 32'(awready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [15:0] pat);
    int t;
    logic stalled;
    logic [31:0] held;
    logic held_last;
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arlen = 8'(len);
    #1; t = 0;
    while (!arready && t < 20) begin @(negedge clk); #1; t++; end
    chk("ar_wait", 32'(t < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    beats = 0; cycles = 0; stalled = 1'b0; held = '0; held_last = 1'b0;
    while (beats <= len && cycles < 100) begin
      rready = pat[cycles % 16];
      #1;
      if (cycles == 0) chk("r_first_latency", 32'(rvalid), 32'd1);
      if (rvalid) begin
        if (stalled) begin
          chk("r_hold_data", rdata, held);
          chk("r_hold_last", 32'(rlast), 32'(held_last));
        end
        if (rready) begin
          rd[beats] = rdata; rl[beats] = rlast; beats++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = rdata; held_last = rlast;
        end
      end
      @(negedge clk);
      cycles++;
    end
    rready = 1'b0;
    #1;
    chk("r_beats", 32'(beats), 32'(len + 1));
    chk("r_done_rvalid", 32'(rvalid), 32'd0);
    chk("r_done_rdata", rdata, 32'd0);
    chk("arready_after_r", 32'(arready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rstn = 1'b1;
    #1;
    chk("idle_arready", 32'(arready), 32'd1);
    chk("idle_awready", 32'(awready), 32'd1);

    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    do_write(32'h100, 3, 4'hF, 3);
    chk("proto_ok", 32'(proto_err), 32'd0);
    do_read(32'h100, 3, 16'hFFFF);
    chk("burst_b0", rd[0], 32'h11);
    chk("burst_b1", rd[1], 32'h22);
    chk("burst_b2", rd[2], 32'h33);
    chk("burst_b3", rd[3], 32'h44);
    chk("burst_rlast", {28'd0, rl[3], rl[2], rl[1], rl[0]}, 32'h8);
    chk("burst_cycles", 32'(cycles), 32'd4);

    wd[0] = 32'h0;
    do_write(32'h200, 0, 4'hF, 0);
    wd[0] = 32'hAABBCCDD;
    do_write(32'h200, 0, 4'b0100, 0);
    do_read(32'h200, 0, 16'hFFFF);
    chk("strb_byte2", rd[0], 32'h00BB0000);
    chk("single_rlast", 32'(rl[0]), 32'd1);

    do_read(32'h100, 3, 16'h9999);
    chk("stall_b0", rd[0], 32'h11);
    chk("stall_b1", rd[1], 32'h22);
    chk("stall_b2", rd[2], 32'h33);
    chk("stall_b3", rd[3], 32'h44);
    chk("stall_rlast", {28'd0, rl[3], rl[2], rl[1], rl[0]}, 32'h8);

    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    do_write(32'h3FF8, 3, 4'hF, 3);
    do_read(32'h3FF8, 3, 16'hFFFF);
    chk("wrap_b0", rd[0], 32'hA0);
    chk("wrap_b1", rd[1], 32'hA1);
    chk("wrap_b2", rd[2], 32'hA2);
    chk("wrap_b3", rd[3], 32'hA3);
    do_read(32'h0, 1, 16'hFFFF);
    chk("wrap_idx0", rd[0], 32'hA2);
    chk("wrap_idx1", rd[1], 32'hA3);
    do_read(32'h1000_0102, 0, 16'hFFFF);
    chk("high_bits_ignored", rd[0], 32'h11);

    wd[0] = 32'h50; wd[1] = 32'h51; wd[2] = 32'h52; wd[3] = 32'h53;
    do_write(32'h300, 3, 4'hF, 2);
    chk("proto_err_set", 32'(proto_err), 32'd1);
    do_read(32'h300, 3, 16'hFFFF);
    chk("proto_b3_written", rd[3], 32'h53);
    repeat (3) @(negedge clk);
    #1 chk("proto_err_sticky", 32'(proto_err), 32'd1);

    @(negedge clk);
    arvalid = 1'b1; araddr = 32'h100; arlen = 8'd3;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    #1;
    chk("mid_rvalid", 32'(rvalid), 32'd1);
    chk("mid_rdata", rdata, 32'h11);
    @(negedge clk);
    rstn = 1'b0;
    #1 chk("mid_rst_arready", 32'(arready), 32'd0);
    @(negedge clk);
    rready = 1'b0;
    #1;
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    chk("post_rst_rlast", 32'(rlast), 32'd0);
    chk("post_rst_proto_err", 32'(proto_err), 32'd0);
    rstn = 1'b1;
    do_read(32'h100, 3, 16'hFFFF);
    chk("fresh_b0", rd[0], 32'h11);
    chk("fresh_b3", rd[3], 32'h44);
    chk("fresh_rlast", {28'd0, rl[3], rl[2], rl[1], rl[0]}, 32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
